// File: rtl/pwm_pkg.sv
// Constants and state encoding shared by the PWM generator and demodulator.
package pwm_pkg;

  localparam int PWM_BITS   = 8;
  localparam int PWM_PERIOD = 256;

  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(PWM_PERIOD - 1);

  typedef enum logic {
    HUNT,
    MEASURE
  } pwm_demod_state_t;

  // A frame carrying sample N is high for N+1 cycles, so the level is one less than the count.
  function automatic logic [PWM_BITS-1:0] pwm_level(input logic [PWM_BITS:0] highCount);
    return PWM_BITS'(highCount - (PWM_BITS + 1)'(1));
  endfunction

endpackage

// File: rtl/pwm_demod_sync_ff.sv
// N-flop bit synchroniser for an asynchronous input, cleared to 0 on reset.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] chain_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[N-2:0], d_i};
    end
  end

  assign q_o = chain_q[N-1];

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: synchronises the PWM line, aligns to 256-cycle frames and
// turns each frame's high time back into an 8-bit sample with lock/error status.
module pwm_demod
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  output logic [PWM_BITS-1:0] sample_out,
  output logic                sample_valid,
  output logic                locked,
  output logic                frame_error
);

  logic                lineSync;
  logic                lineDly_q;
  logic                rise;

  pwm_demod_state_t    state_q, state_d;
  logic [PWM_BITS-1:0] frameCnt_q, frameCnt_d;
  logic [PWM_BITS:0]   highCnt_q, highCnt_d;
  logic [PWM_BITS-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                locked_q, locked_d;
  logic                error_q, error_d;

  sync_ff #(
    .N(SYNC_STAGES)
  ) uSync (
    .clk  (clk),
    .reset(reset),
    .d_i  (pwm_in),
    .q_o  (lineSync)
  );

  assign rise = lineSync & ~lineDly_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lineDly_q  <= 1'b0;
      state_q    <= HUNT;
      frameCnt_q <= '0;
      highCnt_q  <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      lineDly_q  <= lineSync;
      state_q    <= state_d;
      frameCnt_q <= frameCnt_d;
      highCnt_q  <= highCnt_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frameCnt_d = frameCnt_q;
    highCnt_d  = highCnt_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    error_d    = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (rise) begin
          state_d    = MEASURE;
          frameCnt_d = PWM_BITS'(1);
          highCnt_d  = (PWM_BITS + 1)'(1);
        end else if (lineSync) begin
          // A full frame of high level with no edge is a full-scale sample.
          if (frameCnt_q == PWM_LAST) begin
            sample_d   = PWM_LAST;
            valid_d    = 1'b1;
            locked_d   = 1'b1;
            state_d    = MEASURE;
            frameCnt_d = '0;
            highCnt_d  = '0;
          end else begin
            frameCnt_d = frameCnt_q + PWM_BITS'(1);
          end
        end else begin
          frameCnt_d = '0;
        end
      end

      MEASURE: begin
        frameCnt_d = frameCnt_q + PWM_BITS'(1);
        highCnt_d  = highCnt_q + {{PWM_BITS{1'b0}}, lineSync};
        if (frameCnt_q == '0) begin
          if (lineSync) begin
            highCnt_d = (PWM_BITS + 1)'(1);
          end else begin
            error_d    = 1'b1;
            locked_d   = 1'b0;
            state_d    = HUNT;
            frameCnt_d = '0;
            highCnt_d  = '0;
          end
        end else if (rise) begin
          // A second edge inside a frame wins over frame end: re-align on it.
          error_d    = 1'b1;
          locked_d   = 1'b0;
          frameCnt_d = PWM_BITS'(1);
          highCnt_d  = (PWM_BITS + 1)'(1);
        end else if (frameCnt_q == PWM_LAST) begin
          sample_d = pwm_level(highCnt_q + {{PWM_BITS{1'b0}}, lineSync});
          valid_d  = 1'b1;
          locked_d = 1'b1;
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign frame_error  = error_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Bench for pwm_demod: a generator model drives the line, and a monitor matches every
// sample_valid / frame_error strobe against a queue of expected events and cycles.
module tb_pwm_demod;
  import pwm_pkg::*;

  localparam int SYNC        = 2;
  localparam int HALF_PERIOD = 5;

  typedef struct packed {
    logic        isError;
    logic [7:0]  value;
    logic [31:0] when;
  } scoreEvent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       locked;
  logic       frame_error;

  int unsigned cyc    = 0;
  int          errors = 0;
  int          checks = 0;
  scoreEvent_t expQ[$];

  pwm_demod #(
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .locked      (locked),
    .frame_error (frame_error)
  );

  always #HALF_PERIOD clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expectEvent(input logic isError, input int value, input int unsigned when);
    scoreEvent_t e;
    e.isError = isError;
    e.value   = 8'(value);
    e.when    = when;
    expQ.push_back(e);
  endtask

  // Frame cycle k is driven before edge start+k, reaches the synced level SYNC-1 edges
  // later and is judged on edge start+k+SYNC; the monitor sees that on the next negedge.
  task automatic applyStimulus(input int level, input int glitchAt, input int errAt, input bit expectSample);
    int unsigned start;
    start = 0;
    for (int k = 0; k < PWM_PERIOD; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = cyc + 1;
        if (errAt >= 0) expectEvent(1'b1, 0, start + errAt + SYNC);
        if (expectSample) expectEvent(1'b0, level, start + PWM_PERIOD - 1 + SYNC);
      end
      pwm_in = (k <= level) || (glitchAt >= 0 && k >= glitchAt && k < glitchAt + 3);
    end
  endtask

  task automatic driveLevel(input logic level, input int cycles, input int errAt);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (k == 0 && errAt >= 0) expectEvent(1'b1, 0, cyc + 1 + errAt + SYNC);
      pwm_in = level;
    end
  endtask

  task automatic resetPulse(input string tag);
    @(negedge clk);
    reset  = 1'b0;
    pwm_in = 1'b0;
    #1;
    checkOutput({tag, " sample_out"}, 32'(sample_out), 0);
    checkOutput({tag, " sample_valid"}, 32'(sample_valid), 0);
    checkOutput({tag, " locked"}, 32'(locked), 0);
    checkOutput({tag, " frame_error"}, 32'(frame_error), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic scoreEvent(input logic isError);
    scoreEvent_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected %s at cycle %0d: got sample_out=%0d, expected no event",
               isError ? "frame_error" : "sample_valid", cyc, sample_out);
    end else begin
      e = expQ.pop_front();
      checkOutput("event kind (1=frame_error)", 32'(isError), 32'(e.isError));
      checkOutput("event cycle", cyc, e.when);
      if (!isError) checkOutput("sample_out", 32'(sample_out), 32'(e.value));
      checkOutput("locked at event", 32'(locked), 32'(!isError));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (frame_error === 1'b1) scoreEvent(1'b1);
      if (sample_valid === 1'b1) scoreEvent(1'b0);
    end
  end

  initial begin
    scoreEvent_t missing;
    reset  = 1'b1;
    pwm_in = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset sample_out", 32'(sample_out), 0);
    checkOutput("reset sample_valid", 32'(sample_valid), 0);
    checkOutput("reset locked", 32'(locked), 0);
    checkOutput("reset frame_error", 32'(frame_error), 0);
    @(negedge clk);
    reset = 1'b1;
    driveLevel(1'b0, 3, -1);

    repeat (4) applyStimulus(8'h80, -1, -1, 1'b1);

    applyStimulus(8'h00, -1, -1, 1'b1);
    applyStimulus(8'h01, -1, -1, 1'b1);
    applyStimulus(8'hFE, -1, -1, 1'b1);
    applyStimulus(8'hFF, -1, -1, 1'b1);
    driveLevel(1'b1, SYNC + 2, -1);

    resetPulse("after sweep");
    repeat (3) applyStimulus(8'hFF, -1, -1, 1'b1);

    // The glitch re-aligns the frame, so the true frame start then lands mid-frame and
    // re-aligns once more before the next clean frame decodes.
    repeat (2) applyStimulus(8'h40, -1, -1, 1'b1);
    applyStimulus(8'h40, 100, 100, 1'b0);
    applyStimulus(8'h40, -1, 0, 1'b1);
    applyStimulus(8'h40, -1, -1, 1'b1);

    driveLevel(1'b0, 600, 0);
    checkOutput("held sample_out after dropout", 32'(sample_out), 32'h40);
    checkOutput("locked after dropout", 32'(locked), 0);
    repeat (2) applyStimulus(8'h80, -1, -1, 1'b1);

    driveLevel(1'b1, 129, -1);
    driveLevel(1'b0, 71, -1);
    resetPulse("mid-frame");
    repeat (2) applyStimulus(8'h80, -1, -1, 1'b1);
    driveLevel(1'b1, SYNC + 4, -1);

    for (int i = 0; i < 1000 && expQ.size() != 0; i++) @(negedge clk);
    while (expQ.size() != 0) begin
      missing = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing %s: got nothing, expected at cycle %0d",
               missing.isError ? "frame_error" : "sample_valid", missing.when);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
